// File: rtl/alu_operand_stage_if.sv
// Handshake and operand bus between the decoder, the operand stage and the ALU.
interface alu_operand_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) ();
  // Upstream instruction side
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic             alu_src;
  logic [4:0]       rs_addr;
  logic [4:0]       rt_addr;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [15:0]      imm;
  logic             flush;
  // Forwarding sources
  logic             exmem_wr;
  logic [4:0]       exmem_rd;
  logic [WIDTH-1:0] exmem_res;
  logic             memwb_wr;
  logic [4:0]       memwb_rd;
  logic [WIDTH-1:0] memwb_res;
  // ALU side
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       operation;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             illegal;
  logic [CNT_W-1:0] stall_cycles;

  // Driver of instructions/forwarding and consumer of ALU operands
  modport master (
    output in_valid, alu_op, funct, alu_src, rs_addr, rt_addr, rs_data, rt_data, imm, flush,
    output exmem_wr, exmem_rd, exmem_res, memwb_wr, memwb_rd, memwb_res, out_ready,
    input  in_ready, out_valid, operation, A, B, illegal, stall_cycles
  );

  // The operand stage itself
  modport slave (
    input  in_valid, alu_op, funct, alu_src, rs_addr, rt_addr, rs_data, rt_data, imm, flush,
    input  exmem_wr, exmem_rd, exmem_res, memwb_wr, memwb_rd, memwb_res, out_ready,
    output in_ready, out_valid, operation, A, B, illegal, stall_cycles
  );
endinterface

// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: decodes the ALU operation, forwards operands and holds them for the ALU
// under a valid/ready handshake, re-snooping forwarding sources while stalled.
module alu_operand_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  alu_operand_stage_if.slave bus
);

  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b110;
  localparam logic [2:0] OpSlt = 3'b111;
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic             out_valid_q, out_valid_d;
  logic [2:0]       operation_q, operation_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [4:0]       rs_q, rs_d;
  logic [4:0]       rt_q, rt_d;
  logic             alu_src_q, alu_src_d;

  logic             accept, hold;
  logic [2:0]       dec_op;
  logic             dec_ill;
  logic [WIDTH-1:0] imm_ext;

  // EX/MEM beats MEM/WB; register 0 never forwards; dflt used when nothing matches.
  function automatic logic [WIDTH-1:0] fwd(
    input logic [4:0]       addr,
    input logic [WIDTH-1:0] dflt,
    input logic             ex_wr,
    input logic [4:0]       ex_rd,
    input logic [WIDTH-1:0] ex_res,
    input logic             wb_wr,
    input logic [4:0]       wb_rd,
    input logic [WIDTH-1:0] wb_res
  );
    if (ex_wr && ex_rd == addr && addr != 5'd0) begin
      return ex_res;
    end else if (wb_wr && wb_rd == addr && addr != 5'd0) begin
      return wb_res;
    end
    return dflt;
  endfunction

  assign bus.in_ready     = ~out_valid_q | bus.out_ready;
  assign accept           = bus.in_valid & bus.in_ready & ~bus.flush;
  assign hold             = out_valid_q & ~bus.out_ready & ~bus.flush;
  assign imm_ext          = {{(WIDTH-16){bus.imm[15]}}, bus.imm};

  assign bus.out_valid    = out_valid_q;
  assign bus.operation    = operation_q;
  assign bus.A            = a_q;
  assign bus.B            = b_q;
  assign bus.illegal      = illegal_q;
  assign bus.stall_cycles = stall_q;

  // Decode ALU operation from the main-decoder class and R-type funct field
  always_comb begin
    dec_op  = 3'b000;
    dec_ill = 1'b0;
    unique case (bus.alu_op)
      2'b00: dec_op = OpAdd;
      2'b01: dec_op = OpSub;
      2'b10: begin
        unique case (bus.funct)
          6'b100000: dec_op = OpAdd;
          6'b100010: dec_op = OpSub;
          6'b101010: dec_op = OpSlt;
          default:   dec_ill = 1'b1;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Next state: flush beats accept beats hold; a consumed entry without replacement drops valid
  always_comb begin
    out_valid_d = out_valid_q;
    operation_d = operation_q;
    a_d         = a_q;
    b_d         = b_q;
    illegal_d   = illegal_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    alu_src_d   = alu_src_q;
    stall_d     = stall_q;

    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      operation_d = dec_op;
      illegal_d   = dec_ill;
      rs_d        = bus.rs_addr;
      rt_d        = bus.rt_addr;
      alu_src_d   = bus.alu_src;
      a_d = fwd(bus.rs_addr, bus.rs_data, bus.exmem_wr, bus.exmem_rd, bus.exmem_res,
                bus.memwb_wr, bus.memwb_rd, bus.memwb_res);
      b_d = bus.alu_src ? imm_ext :
            fwd(bus.rt_addr, bus.rt_data, bus.exmem_wr, bus.exmem_rd, bus.exmem_res,
                bus.memwb_wr, bus.memwb_rd, bus.memwb_res);
    end else if (hold) begin
      // Held operands keep tracking results that land while the ALU is stalled
      a_d = fwd(rs_q, a_q, bus.exmem_wr, bus.exmem_rd, bus.exmem_res,
                bus.memwb_wr, bus.memwb_rd, bus.memwb_res);
      if (!alu_src_q) begin
        b_d = fwd(rt_q, b_q, bus.exmem_wr, bus.exmem_rd, bus.exmem_res,
                  bus.memwb_wr, bus.memwb_rd, bus.memwb_res);
      end
    end else if (out_valid_q) begin
      out_valid_d = 1'b0;
    end

    if (hold && stall_q != CntMax) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Stage registers with synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      operation_q <= 3'b000;
      a_q         <= '0;
      b_q         <= '0;
      illegal_q   <= 1'b0;
      stall_q     <= '0;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      alu_src_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      operation_q <= operation_d;
      a_q         <= a_d;
      b_q         <= b_d;
      illegal_q   <= illegal_d;
      stall_q     <= stall_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      alu_src_q   <= alu_src_d;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: vector table through a scoreboard queue, then hand-written
// hold/snoop, flush, saturation and reset-during-hold sequences.
module tb_alu_operand_stage;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 4;  // small counter so saturation is reachable quickly

  typedef struct {
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        alu_src;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [15:0] imm;
    logic        ex_wr;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        wb_wr;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic [2:0]  e_op;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        e_ill;
  } vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vecs[9];

  alu_operand_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  alu_operand_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.alu_op    = v.alu_op;
    bus.funct     = v.funct;
    bus.alu_src   = v.alu_src;
    bus.rs_addr   = v.rs_addr;
    bus.rt_addr   = v.rt_addr;
    bus.rs_data   = v.rs_data;
    bus.rt_data   = v.rt_data;
    bus.imm       = v.imm;
    bus.exmem_wr  = v.ex_wr;
    bus.exmem_rd  = v.ex_rd;
    bus.exmem_res = v.ex_res;
    bus.memwb_wr  = v.wb_wr;
    bus.memwb_rd  = v.wb_rd;
    bus.memwb_res = v.wb_res;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.op  = v.e_op;
    e.a   = v.e_a;
    e.b   = v.e_b;
    e.ill = v.e_ill;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".operation"}, {29'd0, bus.operation}, {29'd0, e.op});
      chk({tag, ".A"}, bus.A, e.a);
      chk({tag, ".B"}, bus.B, e.b);
      chk({tag, ".illegal"}, {31'd0, bus.illegal}, {31'd0, e.ill});
    end
  endtask

  initial begin
    vec_t hv;
    // alu_op funct src rs rt rs_data rt_data imm | exmem | memwb | op A B ill
    vecs[0] = '{2'b10, 6'b101010, 1'b0, 5'd3, 5'd4, 32'h5, 32'h9, 16'h0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'b111, 32'h5, 32'h9, 1'b0};
    vecs[1] = '{2'b00, 6'b000000, 1'b1, 5'd1, 5'd2, 32'h10, 32'h3, 16'hFFFC,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'b010, 32'h10, 32'hFFFFFFFC, 1'b0};
    vecs[2] = '{2'b00, 6'b000000, 1'b0, 5'd7, 5'd7, 32'h1, 32'h2, 16'h0,
                1'b1, 5'd7, 32'hAA, 1'b1, 5'd7, 32'hBB, 3'b010, 32'hAA, 32'hAA, 1'b0};
    vecs[3] = '{2'b01, 6'b000000, 1'b0, 5'd0, 5'd0, 32'h123, 32'h456, 16'h0,
                1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB, 3'b110, 32'h123, 32'h456, 1'b0};
    vecs[4] = '{2'b10, 6'b000000, 1'b0, 5'd1, 5'd2, 32'h11, 32'h22, 16'h0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'b000, 32'h11, 32'h22, 1'b1};
    vecs[5] = '{2'b11, 6'b100000, 1'b0, 5'd1, 5'd2, 32'h33, 32'h44, 16'h0,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'b000, 32'h33, 32'h44, 1'b1};
    vecs[6] = '{2'b10, 6'b100010, 1'b0, 5'd2, 5'd5, 32'h66, 32'h1, 16'h0,
                1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h55, 3'b110, 32'h66, 32'h55, 1'b0};
    vecs[7] = '{2'b10, 6'b100000, 1'b1, 5'd8, 5'd9, 32'h80, 32'h90, 16'h7FFF,
                1'b0, 5'd8, 32'hEE, 1'b0, 5'd0, 32'h0, 3'b010, 32'h80, 32'h00007FFF, 1'b0};
    vecs[8] = '{2'b00, 6'b000000, 1'b0, 5'd9, 5'd10, 32'h1, 32'h2, 16'h0,
                1'b1, 5'd9, 32'hCC, 1'b1, 5'd10, 32'hDD, 3'b010, 32'hCC, 32'hDD, 1'b0};

    // Reset with an instruction offered: nothing may be captured
    drive(vecs[0]);
    bus.in_valid  = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset.operation", {29'd0, bus.operation}, 32'd0);
    chk("reset.A", bus.A, 32'd0);
    chk("reset.B", bus.B, 32'd0);
    chk("reset.illegal", {31'd0, bus.illegal}, 32'd0);
    chk("reset.stall", {28'd0, bus.stall_cycles}, 32'd0);
    chk("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
    rst = 1'b0;

    // Back-to-back vectors at full throughput
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i]);
      bus.in_valid = 1'b1;
      push_exp(vecs[i]);
      step();
      chk($sformatf("vec%0d.out_valid", i), {31'd0, bus.out_valid}, 32'd1);
      pop_check($sformatf("vec%0d", i));
    end
    bus.in_valid = 1'b0;
    bus.exmem_wr = 1'b0;
    bus.memwb_wr = 1'b0;
    step();
    chk("consume.out_valid", {31'd0, bus.out_valid}, 32'd0);

    // Hold three cycles; MEM/WB result for rs lands on the second held cycle
    hv = '{2'b00, 6'b000000, 1'b0, 5'd6, 5'd8, 32'h1, 32'h2, 16'h0,
           1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 3'b010, 32'h77, 32'h2, 1'b0};
    drive(hv);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    push_exp(hv);
    step();
    chk("hold.out_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("hold.in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.rs_data = 32'hDEAD;  // offered but must not be accepted
    step();
    bus.memwb_wr  = 1'b1;
    bus.memwb_rd  = 5'd6;
    bus.memwb_res = 32'h77;
    step();
    bus.memwb_wr = 1'b0;
    step();
    chk("hold.stall", {28'd0, bus.stall_cycles}, 32'd3);
    chk("hold.in_ready2", {31'd0, bus.in_ready}, 32'd0);
    chk("hold.out_valid2", {31'd0, bus.out_valid}, 32'd1);
    pop_check("hold");
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    step();
    chk("release.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("release.stall", {28'd0, bus.stall_cycles}, 32'd3);

    // Flush together with in_valid: nothing captured
    drive(vecs[0]);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    step();
    chk("flush_in.out_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    chk("flush_hold.pre_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_hold.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_hold.in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("flush_hold.stall", {28'd0, bus.stall_cycles}, 32'd3);

    // Long stall saturates the counter
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat.stall", {28'd0, bus.stall_cycles}, 32'd15);
    chk("sat.out_valid", {31'd0, bus.out_valid}, 32'd1);

    // Reset during hold with in_valid high
    bus.in_valid = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_hold.out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_hold.stall", {28'd0, bus.stall_cycles}, 32'd0);
    chk("rst_hold.A", bus.A, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
